regfile_multiport: RTL and testbench
====================================

# regfile_multiport

Parametrised multi-port register file for the LEGv8 datapath. It stores DEPTH words of WIDTH bits, with one synchronous write port and NREAD independent combinational read ports. Each read port is built from a per-bit DEPTH:1 selection tree. The highest-numbered register is hardwired to zero (XZR). It replaces the fixed 32x64 single-read-mux arrangement in the decode stage and supplies both operand reads, plus an optional third read for stores, in one instance.

## Interface
Parameters:
- WIDTH, 64, data bits per register.
- DEPTH, 32, number of registers; power of two, minimum 2.
- NREAD, 2, number of read ports; minimum 1, maximum 4.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk.
- RegWrite  input  1  write enable.
- WriteRegister  input  AW  write address.
- WriteData  input  WIDTH  write data.
- ReadRegister  input  NREAD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- ReadData  output  NREAD*WIDTH  packed read data; port k occupies bits [k*WIDTH +: WIDTH].
- WriteAck  output  1  registered; high for exactly one cycle after a write that changed state.

## Operation
- Storage: registers 0..DEPTH-2 are flops. Register DEPTH-1 (ZR) has no storage.
- Write: on a rising clk with reset=0, RegWrite=1 and WriteRegister != DEPTH-1, the addressed register takes WriteData. All other registers hold.
- A write to ZR is discarded silently, and WriteAck stays 0 for it.
- Read: ReadData[k] = mem[ReadRegister[k]], combinational with no clock in the path. A read of ZR returns all zeros.
- Several ports may address the same register; each port returns the same value.
- WriteAck is set the cycle after an accepted write and cleared otherwise.
- Reset: a rising clk with reset=1 clears every stored register to 0 and clears WriteAck to 0. Any write in that same cycle is ignored, because reset wins.
- After reset, every ReadData port reads 0 for every address.
- Reset asserted mid-sequence: the state is fully cleared at that edge, no partial write survives, and there is no recovery cycle.
- Width rules: no sign extension or truncation. An out-of-range address cannot occur because DEPTH is a power of two.

## Timing
- Write-to-storage latency: 1 edge.
- Read latency: 0 cycles (combinational); the path is decode plus a DEPTH:1 tree per bit.
- Without bypass, a read of register R in the same cycle that R is written returns the OLD value. The new value appears after the edge.
- WriteAck: asserts 1 cycle after the write edge and lasts 1 cycle. Back-to-back writes keep it high continuously.
- Simultaneous reset and RegWrite: reset wins, the register becomes 0 and WriteAck becomes 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Each read port compares ReadRegister[k] with WriteRegister while RegWrite=1 and reset=0.
  - On a match with a non-ZR address, ReadData[k] = WriteData in the same cycle (write-through forwarding).
  - ZR still reads 0. This lets a single-cycle or pipelined core write back and read in the same cycle without a hazard.
- REGFILE_BYPASS_EN undefined:
  - No comparators are built.
  - Same-cycle reads return the pre-write value, as described in Timing.

## Test plan
- Reset: hold reset=1 for 2 cycles with RegWrite=1, WriteRegister=5, WriteData=64'hFFFF. Then read all 32 addresses on both ports -> all 0, WriteAck=0.
- Write/read: write R3=64'hDEADBEEF_CAFEF00D. The next cycle, port0=3 and port1=3 -> both return that value, and WriteAck=1 for exactly one cycle.
- ZR: write R31=64'h1234 -> WriteAck stays 0 and a read of 31 returns 0. R0..R30 are unchanged (compare against the scoreboard).
- Same-cycle read of a register being written: R7 holds 64'h1 and the bench writes R7=64'h2 while reading R7.
  - Bypass undefined -> reads 64'h1 before the edge and 64'h2 after.
  - REGFILE_BYPASS_EN defined -> reads 64'h2 before the edge.
- Parameter sweep:
  - WIDTH=32, DEPTH=16, NREAD=3: write i*3+1 to R0..R14, then randomly read all three ports for 1000 cycles -> matches the model, and R15 always reads 0.
  - Also run WIDTH=8, DEPTH=2, NREAD=1, which has a single real register.
- Reset mid-stream: write back-to-back to R1..R4, asserting reset on the R3 write edge -> R1..R4 all 0 and WriteAck 0 on the next cycle. The R4 write after reset deasserts succeeds.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multi-port LEGv8 register file: DEPTH x WIDTH, one synchronous write port, NREAD combinational read ports, top register hardwired to zero (XZR).
// Optional write-through forwarding on every read port is enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int NREAD = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RegWrite,
  input  logic [AW-1:0]          WriteRegister,
  input  logic [WIDTH-1:0]       WriteData,
  input  logic [NREAD*AW-1:0]    ReadRegister,
  output logic [NREAD*WIDTH-1:0] ReadData,
  output logic                   WriteAck
);

  localparam logic [AW-1:0] ZR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem  [DEPTH-1];
  logic [WIDTH-1:0] view [DEPTH];
  logic             write_ok;

  assign write_ok = RegWrite && (WriteRegister != ZR);

  // Reset takes priority over any write presented on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem[i] <= '0;
      end
      WriteAck <= 1'b0;
    end else begin
      WriteAck <= write_ok;
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (write_ok && (WriteRegister == AW'(i))) begin
          mem[i] <= WriteData;
        end
      end
    end
  end

  for (genvar r = 0; r < DEPTH - 1; r++) begin : g_view
    assign view[r] = mem[r];
  end
  assign view[DEPTH-1] = '0;

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;

    assign addr = ReadRegister[k*AW +: AW];

    // ZR never forwards, so a write aimed at it stays invisible on every path.
    always_comb begin
      data = view[addr];
`ifdef REGFILE_BYPASS_EN
      if (RegWrite && !reset && (addr == WriteRegister) && (addr != ZR)) begin
        data = WriteData;
      end
`endif
    end

    assign ReadData[k*WIDTH +: WIDTH] = data;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: three configurations (64x32x2, 32x16x3, 8x2x1) checked against array models.
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_multiport;

  logic clk;

  logic         a_rst, a_we, a_ack;
  logic [4:0]   a_wa;
  logic [63:0]  a_wd;
  logic [9:0]   a_ra;
  logic [127:0] a_rd;

  logic         b_rst, b_we, b_ack;
  logic [3:0]   b_wa;
  logic [31:0]  b_wd;
  logic [11:0]  b_ra;
  logic [95:0]  b_rd;

  logic         c_rst, c_we, c_ack;
  logic [0:0]   c_wa;
  logic [7:0]   c_wd;
  logic [0:0]   c_ra;
  logic [7:0]   c_rd;

  logic [63:0] ma [32];
  logic [31:0] mb [16];
  logic [7:0]  mc [2];
  logic        ea, eb, ec;

  int nChecks = 0;
  int nFails  = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [63:0] SAME_CYCLE_R7 = 64'h2;
`else
  localparam logic [63:0] SAME_CYCLE_R7 = 64'h1;
`endif

  regfile_multiport #(.WIDTH(64), .DEPTH(32), .NREAD(2)) dut_a (
    .clk(clk), .reset(a_rst), .RegWrite(a_we), .WriteRegister(a_wa), .WriteData(a_wd),
    .ReadRegister(a_ra), .ReadData(a_rd), .WriteAck(a_ack)
  );

  regfile_multiport #(.WIDTH(32), .DEPTH(16), .NREAD(3)) dut_b (
    .clk(clk), .reset(b_rst), .RegWrite(b_we), .WriteRegister(b_wa), .WriteData(b_wd),
    .ReadRegister(b_ra), .ReadData(b_rd), .WriteAck(b_ack)
  );

  regfile_multiport #(.WIDTH(8), .DEPTH(2), .NREAD(1)) dut_c (
    .clk(clk), .reset(c_rst), .RegWrite(c_we), .WriteRegister(c_wa), .WriteData(c_wd),
    .ReadRegister(c_ra), .ReadData(c_rd), .WriteAck(c_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge with the inputs currently driven; the models take the same edge.
  task automatic applyStimulus();
    @(posedge clk);
    if (a_rst) begin
      foreach (ma[i]) ma[i] = '0;
      ea = 1'b0;
    end else begin
      ea = a_we && (a_wa != 5'd31);
      if (ea) ma[a_wa] = a_wd;
    end
    if (b_rst) begin
      foreach (mb[i]) mb[i] = '0;
      eb = 1'b0;
    end else begin
      eb = b_we && (b_wa != 4'd15);
      if (eb) mb[b_wa] = b_wd;
    end
    if (c_rst) begin
      foreach (mc[i]) mc[i] = '0;
      ec = 1'b0;
    end else begin
      ec = c_we && (c_wa != 1'b1);
      if (ec) mc[c_wa] = c_wd;
    end
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expA(input logic [4:0] ad);
    logic [63:0] v;
    v = ma[ad];
`ifdef REGFILE_BYPASS_EN
    if (a_we && !a_rst && (ad == a_wa) && (ad != 5'd31)) v = a_wd;
`endif
    return v;
  endfunction

  function automatic logic [31:0] expB(input logic [3:0] ad);
    logic [31:0] v;
    v = mb[ad];
`ifdef REGFILE_BYPASS_EN
    if (b_we && !b_rst && (ad == b_wa) && (ad != 4'd15)) v = b_wd;
`endif
    return v;
  endfunction

  function automatic logic [7:0] expC(input logic [0:0] ad);
    logic [7:0] v;
    v = mc[ad];
`ifdef REGFILE_BYPASS_EN
    if (c_we && !c_rst && (ad == c_wa) && (ad != 1'b1)) v = c_wd;
`endif
    return v;
  endfunction

  task automatic checkReadsA(input string tag);
    #1;
    checkOutput({tag, "_a_ack"}, a_ack, ea);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s_a_rd%0d_r%0d", tag, k, a_ra[k*5 +: 5]), a_rd[k*64 +: 64], expA(a_ra[k*5 +: 5]));
    end
  endtask

  task automatic checkReadsB(input string tag);
    #1;
    checkOutput({tag, "_b_ack"}, b_ack, eb);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("%s_b_rd%0d_r%0d", tag, k, b_ra[k*4 +: 4]), b_rd[k*32 +: 32], expB(b_ra[k*4 +: 4]));
    end
  endtask

  task automatic checkReadsC(input string tag);
    #1;
    checkOutput({tag, "_c_ack"}, c_ack, ec);
    checkOutput($sformatf("%s_c_rd_r%0d", tag, c_ra), c_rd, expC(c_ra));
  endtask

  initial begin
    // Reset held for two edges while a write is also requested.
    a_rst = 1'b1; a_we = 1'b1; a_wa = 5'd5; a_wd = 64'hFFFF; a_ra = '0;
    b_rst = 1'b1; b_we = 1'b0; b_wa = '0;   b_wd = '0;       b_ra = '0;
    c_rst = 1'b1; c_we = 1'b0; c_wa = '0;   c_wd = '0;       c_ra = '0;
    applyStimulus();
    applyStimulus();
    a_rst = 1'b0; a_we = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    #1;
    checkOutput("reset_ack", a_ack, 1'b0);
    for (int r = 0; r < 32; r++) begin
      a_ra = {5'(31 - r), 5'(r)};
      checkReadsA("reset_sweep");
      checkOutput($sformatf("reset_zero_r%0d", r), a_rd, 128'h0);
      applyStimulus();
    end

    // Simple write then read on both ports.
    a_we = 1'b1; a_wa = 5'd3; a_wd = 64'hDEADBEEF_CAFEF00D;
    applyStimulus();
    a_we = 1'b0; a_ra = {5'd3, 5'd3};
    checkReadsA("wr_r3");
    checkOutput("r3_value", a_rd, {64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D});
    checkOutput("r3_ack_high", a_ack, 1'b1);
    applyStimulus();
    checkReadsA("wr_r3_next");
    checkOutput("r3_ack_low", a_ack, 1'b0);

    // Random writes and reads against the model.
    for (int n = 0; n < 80; n++) begin
      a_we = 1'($urandom_range(0, 1));
      a_wa = 5'($urandom);
      a_wd = {$urandom, $urandom};
      a_ra = 10'($urandom);
      checkReadsA("rand");
      applyStimulus();
    end
    a_we = 1'b0;

    // Write to ZR is dropped and acknowledges nothing.
    a_we = 1'b1; a_wa = 5'd31; a_wd = 64'h1234;
    applyStimulus();
    a_we = 1'b0;
    #1;
    checkOutput("zr_ack", a_ack, 1'b0);
    for (int r = 0; r < 32; r++) begin
      a_ra = {5'd31, 5'(r)};
      checkReadsA("zr_sweep");
      applyStimulus();
    end

    // Same-cycle read of the register being written.
    a_we = 1'b1; a_wa = 5'd7; a_wd = 64'h1;
    applyStimulus();
    a_wd = 64'h2; a_ra = {5'd7, 5'd7};
    checkReadsA("r7_pre");
    checkOutput("r7_pre_value", a_rd[63:0], SAME_CYCLE_R7);
    applyStimulus();
    a_we = 1'b0;
    checkReadsA("r7_post");
    checkOutput("r7_post_value", a_rd[63:0], 64'h2);

    // Back-to-back writes with reset landing on the R3 edge.
    a_we = 1'b1; a_wa = 5'd1; a_wd = 64'd11;
    applyStimulus();
    a_wa = 5'd2; a_wd = 64'd22;
    #1;
    checkOutput("b2b_ack_r1", a_ack, 1'b1);
    applyStimulus();
    a_wa = 5'd3; a_wd = 64'd33; a_rst = 1'b1;
    #1;
    checkOutput("b2b_ack_r2", a_ack, 1'b1);
    applyStimulus();
    a_rst = 1'b0; a_we = 1'b0; a_ra = {5'd2, 5'd1};
    checkReadsA("mid_rst_12");
    checkOutput("mid_rst_ack", a_ack, 1'b0);
    checkOutput("mid_rst_r12", a_rd, 128'h0);
    applyStimulus();
    a_ra = {5'd4, 5'd3};
    checkReadsA("mid_rst_34");
    checkOutput("mid_rst_r34", a_rd, 128'h0);
    a_we = 1'b1; a_wa = 5'd4; a_wd = 64'd44;
    applyStimulus();
    a_we = 1'b0; a_ra = {5'd4, 5'd4};
    checkReadsA("r4_after_rst");
    checkOutput("r4_value", a_rd[63:0], 64'd44);

    // 32x16x3 sweep: fill R0..R14, try R15, then random reads.
    b_we = 1'b1;
    for (int i = 0; i < 15; i++) begin
      b_wa = 4'(i);
      b_wd = 32'(i * 3 + 1);
      applyStimulus();
    end
    b_wa = 4'd15; b_wd = 32'hFFFF_FFFF;
    applyStimulus();
    b_we = 1'b0;
    #1;
    checkOutput("b_zr_ack", b_ack, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      b_ra = 12'($urandom);
      checkReadsB("b_rand");
      applyStimulus();
    end
    b_ra = {4'd15, 4'd14, 4'd0};
    #1;
    checkOutput("b_fixed", b_rd, {32'h0, 32'd43, 32'd1});
    applyStimulus();

    // 8x2x1: only R0 is real storage.
    c_we = 1'b1; c_wa = 1'b0; c_wd = 8'($urandom);
    applyStimulus();
    c_we = 1'b0; c_ra = 1'b0;
    checkReadsC("c_r0");
    applyStimulus();
    c_ra = 1'b1;
    checkReadsC("c_r1");
    checkOutput("c_r1_zero", c_rd, 8'h0);
    c_we = 1'b1; c_wa = 1'b1; c_wd = 8'hAA;
    applyStimulus();
    c_we = 1'b0; c_ra = 1'b0;
    checkReadsC("c_after_zr");
    checkOutput("c_zr_ack", c_ack, 1'b0);
    for (int n = 0; n < 20; n++) begin
      c_we = 1'($urandom_range(0, 1));
      c_wa = 1'($urandom);
      c_wd = 8'($urandom);
      c_ra = 1'($urandom);
      checkReadsC("c_rand");
      applyStimulus();
    end
    c_rst = 1'b1; c_we = 1'b1; c_wa = 1'b0; c_wd = 8'hFF;
    applyStimulus();
    c_rst = 1'b0; c_we = 1'b0; c_ra = 1'b0;
    checkReadsC("c_rst");
    checkOutput("c_rst_zero", c_rd, 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
